// File: rtl/mxv_uart_controller.sv
// mxv_uart_controller: receives a framed N x N matrix and vector as UART bytes,
// computes y = M*v one MAC per cycle and streams saturated y[i] words to the transmitter.
module mxv_uart_controller #(
   parameter int DATA_W = 8,
   parameter int MAX_N = 8,
   parameter int OUT_W = 16,
   parameter logic [7:0] SOF = 8'hFE,
   parameter logic [7:0] EOF = 8'hEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             tx_busy,
   output logic [OUT_W-1:0] tx_data,
   output logic             tx_start,
   output logic             busy,
   output logic             frame_err,
   output logic             done
);
   localparam int CW = $clog2(MAX_N + 1);
   localparam int IW = $clog2(MAX_N * MAX_N);
   localparam int AW = 2 * DATA_W + $clog2(MAX_N);
   typedef enum logic [3:0] {IDLE, GET_N, GET_MAT, GET_VEC, GET_EOF, COMPUTE, SEND, WAIT_HI, WAIT_LO} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] n, row, col;
   logic [IW-1:0] idx, addr, nn_last, n_last;
   logic [AW-1:0] acc;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0] mat [MAX_N*MAX_N];
   logic [DATA_W-1:0] vec [MAX_N];
   logic n_ok, last_row, err_nxt, done_nxt, start_nxt;
   assign n_ok     = rx_data != 8'd0 && rx_data <= 8'(MAX_N);
   assign nn_last  = IW'(n) * IW'(n) - IW'(1);
   assign n_last   = IW'(n) - IW'(1);
   assign last_row = row == n - CW'(1);
   assign addr     = IW'(row) * IW'(n) + IW'(col);
   assign prod     = mat[addr] * vec[col];
   assign busy     = state != IDLE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      done_nxt  = 1'b0;
      start_nxt = 1'b0;
      case (state)
         IDLE:    if (rx_valid && rx_data == SOF) state_nxt = GET_N;
         GET_N:   if (rx_valid) begin
                     state_nxt = n_ok ? GET_MAT : IDLE;
                     err_nxt   = !n_ok;
                  end
         GET_MAT: if (rx_valid && idx == nn_last) state_nxt = GET_VEC;
         GET_VEC: if (rx_valid && idx == n_last) state_nxt = GET_EOF;
         GET_EOF: if (rx_valid) begin
                     state_nxt = rx_data == EOF ? COMPUTE : IDLE;
                     err_nxt   = rx_data != EOF;
                  end
         COMPUTE: if (col == n) state_nxt = SEND;
         SEND:    if (!tx_busy) begin
                     state_nxt = WAIT_HI;
                     start_nxt = 1'b1;
                  end
         WAIT_HI: if (tx_busy) state_nxt = WAIT_LO;
         WAIT_LO: if (!tx_busy) begin
                     state_nxt = last_row ? IDLE : COMPUTE;
                     done_nxt  = last_row;
                  end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         n         <= '0;
         row       <= '0;
         col       <= '0;
         idx       <= '0;
         acc       <= '0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         frame_err <= 1'b0;
         done      <= 1'b0;
      end else begin
         tx_start  <= start_nxt;
         frame_err <= err_nxt;
         done      <= done_nxt;
         case (state)
            GET_N:   if (rx_valid) begin
                        n   <= CW'(rx_data);
                        idx <= '0;
                     end
            GET_MAT: if (rx_valid) idx <= idx == nn_last ? '0 : idx + IW'(1);
            GET_VEC: if (rx_valid) idx <= idx + IW'(1);
            GET_EOF: begin
                        row <= '0;
                        col <= '0;
                        acc <= '0;
                     end
            // the extra cycle after the last column loads the saturated result
            COMPUTE: if (col == n) tx_data <= (acc >> OUT_W) != '0 ? '1 : OUT_W'(acc);
                     else begin
                        acc <= acc + AW'(prod);
                        col <= col + CW'(1);
                     end
            WAIT_LO: if (!tx_busy && !last_row) begin
                        row <= row + CW'(1);
                        col <= '0;
                        acc <= '0;
                     end
            default: ;
         endcase
      end
   always_ff @(posedge clk) begin
      if (state == GET_MAT && rx_valid) mat[idx] <= DATA_W'(rx_data);
      if (state == GET_VEC && rx_valid) vec[idx] <= DATA_W'(rx_data);
   end
endmodule

// File: tb/tb_mxv_uart_controller.sv
// tb_mxv_uart_controller: randomized frames against a sum-of-products reference model,
// with a UART busy emulator and a scoreboard monitor for tx words and pulses.
module tb_mxv_uart_controller;
   localparam int MAX_N = 8;
   localparam byte EV_E = 1, EV_D = 2;
   logic clk, rst, rx_valid, tx_busy, tx_start, busy, frame_err, done;
   logic [7:0] rx_data;
   logic [15:0] tx_data;
   int checks = 0, errors = 0, busy_len = 3, cyc = 0, last_start = -100;
   logic [15:0] exp_q[$];
   byte ev_q[$];
   logic [15:0] held;
   bit held_v = 0, stab_bad = 0, prev_busy = 0;

   mxv_uart_controller dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
      .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .frame_err(frame_err), .done(done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic evchk(input byte c, input string name);
      byte e;
      checks++;
      if (ev_q.size() == 0) begin
         errors++;
         $display("FAIL %s actual=pulse required=no_pulse", name);
      end else begin
         e = ev_q.pop_front();
         if (e != c) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, c, e);
         end
      end
   endtask

   // transmitter emulator: busy from the cycle after tx_start for busy_len cycles
   initial begin
      tx_busy = 0;
      forever begin
         @(negedge clk);
         if (rst && tx_start) begin
            @(posedge clk);
            #1 tx_busy = 1;
            repeat (busy_len) @(posedge clk);
            #1 tx_busy = 0;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         held_v = 0;
         prev_busy = 0;
      end else begin
         if (tx_start) begin
            chk("tx_start_gap", 32'(cyc - last_start >= 3), 1);
            last_start = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_tx_start actual=%0h required=none", tx_data);
            end else chk("tx_word", 32'(tx_data), 32'(exp_q.pop_front()));
            held = tx_data;
            held_v = 1;
            stab_bad = 0;
         end
         if (held_v && tx_busy && tx_data !== held) stab_bad = 1;
         if (held_v && prev_busy && !tx_busy) begin
            chk("tx_data_stable", 32'(stab_bad), 0);
            held_v = 0;
         end
         prev_busy = tx_busy;
         if (frame_err) evchk(EV_E, "frame_err");
         if (done) evchk(EV_D, "done");
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1;
      @(posedge clk);
      #1 rx_valid = 0;
      repeat ($urandom_range(0, 1)) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mode 0 random, 1 all 0xFF, 2 bytes 1,2,3,...
   task automatic send_frame(input int n, input int mode, input bit bad_eof);
      int m[256];
      int v[16];
      int s;
      for (int i = 0; i < n * n; i++) m[i] = mode == 1 ? 255 : mode == 2 ? i + 1 : int'($urandom_range(0, 255));
      for (int j = 0; j < n; j++) v[j] = mode == 1 ? 255 : mode == 2 ? n * n + j + 1 : int'($urandom_range(0, 255));
      if (bad_eof) ev_q.push_back(EV_E);
      else begin
         for (int i = 0; i < n; i++) begin
            s = 0;
            for (int j = 0; j < n; j++) s += m[i * n + j] * v[j];
            exp_q.push_back(s > 65535 ? 16'hFFFF : 16'(s));
         end
         ev_q.push_back(EV_D);
      end
      send_byte(8'hFE);
      send_byte(8'(n));
      for (int i = 0; i < n * n; i++) send_byte(8'(m[i]));
      for (int j = 0; j < n; j++) send_byte(8'(v[j]));
      send_byte(bad_eof ? 8'h00 : 8'hEF);
   endtask

   task automatic wait_done(input int limit, input bit noise);
      int k = 0;
      while ((exp_q.size() > 0 || ev_q.size() > 0 || busy) && k < limit) begin
         if (noise && ev_q.size() > 0 && $urandom_range(0, 3) == 0) begin
            rx_data = 8'($urandom_range(0, 8'hFD));
            rx_valid = 1;
         end
         @(posedge clk);
         #1 rx_valid = 0;
         k++;
      end
      chk("completion_timeout", 32'(k >= limit), 0);
   endtask

   initial begin
      int k;
      bit hi;
      rst = 0;
      rx_valid = 0;
      rx_data = 0;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", {tx_data, tx_start, busy, frame_err, done}, 0);
      rst = 1;
      @(posedge clk);
      #1;
      send_frame(2, 2, 0);
      wait_done(2000, 0);
      send_frame(8, 1, 0);
      wait_done(4000, 0);
      send_byte(8'hFE);
      send_byte(8'h00);
      ev_q.push_back(EV_E);
      wait_done(100, 0);
      chk("idle_after_bad_n0", 32'(busy), 0);
      ev_q.push_back(EV_E);
      send_byte(8'hFE);
      send_byte(8'(MAX_N + 1));
      wait_done(100, 0);
      chk("idle_after_bad_nmax", 32'(busy), 0);
      send_frame(2, 0, 0);
      wait_done(2000, 0);
      send_frame(2, 0, 1);
      wait_done(100, 0);
      chk("idle_after_bad_eof", 32'(busy), 0);
      send_frame(3, 0, 0);
      wait_done(2000, 0);
      send_frame(1, 0, 0);
      wait_done(2000, 0);
      busy_len = 500;
      send_frame(2, 0, 0);
      wait_done(3000, 1);
      for (int f = 0; f < 15; f++) begin
         busy_len = $urandom_range(1, 12);
         send_frame($urandom_range(1, MAX_N), $urandom_range(0, 3) == 0 ? 1 : 0, 0);
         wait_done(4000, f[0]);
      end
      busy_len = 2;
      send_frame(4, 0, 0);
      hi = 0;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_q.size() <= 3 && tx_busy) hi = 1;
         if (hi && !tx_busy) break;
      end
      chk("row0_timeout", 32'(k >= 3000), 0);
      @(posedge clk);
      #3 rst = 0;
      exp_q.delete();
      ev_q.delete();
      #1 chk("async_reset_outputs", {tx_data, tx_start, busy, frame_err, done}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1;
      repeat (30) @(posedge clk);
      #1 chk("idle_after_reset", 32'(busy), 0);
      send_frame(4, 0, 0);
      wait_done(2000, 0);
      chk("queues_empty", 32'(exp_q.size() + ev_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
